// File: rtl/popcnt_share_sched.sv
// Round-robin scheduler sharing one 16-bit popcount unit among N_REQ packet streams.
// Each granted packet's set bits are summed (saturating) and returned tagged with its owner.
module popcnt_share_sched #(
  parameter int N_REQ = 4,
  parameter int ACC_W = 12,
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_count,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_sat,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESULT
  } state_t;

  localparam logic [ID_W:0]   N_REQ_V  = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sat;
  logic [ACC_W-1:0]  r_resCount;
  logic [ID_W-1:0]   r_resId;
  logic              r_resSat;

  logic [ID_W-1:0]   w_winner;
  logic              w_anyValid;
  logic [15:0]       w_beat;
  logic [4:0]        w_pc;
  logic              w_xfer;
  logic              w_lastBeat;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_accNext;
  logic              w_satNext;
  logic [ID_W-1:0]   w_ptrNext;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rrPick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   idx;
    logic            found;
    logic [ID_W-1:0] pick;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= N_REQ_V) idx = idx - N_REQ_V;
      if (!found && valid[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] d);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(d[i]);
    return cnt;
  endfunction

  assign w_anyValid = |req_valid;
  assign w_winner   = rrPick(req_valid, r_ptr);
  assign w_beat     = req_data[{r_grant, 4'b0000} +: 16];
  assign w_pc       = popcount16(w_beat);
  assign w_xfer     = (r_state == S_ACCUM) && req_valid[r_grant];
  assign w_lastBeat = req_last[r_grant];
  assign w_ptrNext  = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  // Once the carry-out sets, the accumulator pins at all-ones and sat stays sticky.
  assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(w_pc);
  assign w_accNext  = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_satNext  = r_sat | w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:   if (w_anyValid) w_stateNext = S_ACCUM;
      S_ACCUM:  if (w_xfer && w_lastBeat) w_stateNext = S_RESULT;
      S_RESULT: if (res_ready) w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_resCount <= '0;
      r_resId    <= '0;
      r_resSat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyValid) begin
            r_grant <= w_winner;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_accNext;
            r_sat <= w_satNext;
            if (w_lastBeat) begin
              r_resCount <= w_accNext;
              r_resSat   <= w_satNext;
              r_resId    <= r_grant;
              r_ptr      <= w_ptrNext;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend only on registered state so no input reaches them combinationally.
  always_comb begin
    req_ready = '0;
    if (r_state == S_ACCUM) req_ready[r_grant] = 1'b1;
  end

  assign res_valid = (r_state == S_RESULT);
  assign busy      = (r_state != S_IDLE);
  assign res_count = r_resCount;
  assign res_id    = r_resId;
  assign res_sat   = r_resSat;

endmodule

// File: tb/tb_popcnt_share_sched.sv
// Scoreboard bench for popcnt_share_sched: a 12-bit and a 5-bit accumulator instance
// share identical stimulus so wide and saturating results are checked side by side.
module tb_popcnt_share_sched;

  localparam int N_REQ     = 4;
  localparam int ACC_W     = 12;
  localparam int ACC_SMALL = 5;
  localparam int MAX_MAIN  = (1 << ACC_W) - 1;
  localparam int MAX_SMALL = (1 << ACC_SMALL) - 1;

  typedef struct {
    int count;
    int id;
    bit sat;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     reqValid;
  logic [N_REQ-1:0]     reqLast;
  logic [16*N_REQ-1:0]  reqData;
  logic                 resReady;

  logic [N_REQ-1:0]     reqReady;
  logic                 resValid;
  logic [ACC_W-1:0]     resCount;
  logic [1:0]           resId;
  logic                 resSat;
  logic                 busy;

  logic [N_REQ-1:0]     reqReady5;
  logic                 resValid5;
  logic [ACC_SMALL-1:0] resCount5;
  logic [1:0]           resId5;
  logic                 resSat5;
  logic                 busy5;

  int checks = 0;
  int errors = 0;
  exp_t sbMain[$];
  exp_t sbSmall[$];

  popcnt_share_sched #(.N_REQ(N_REQ), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_last(reqLast), .req_data(reqData), .req_ready(reqReady),
    .res_valid(resValid), .res_ready(resReady), .res_count(resCount), .res_id(resId),
    .res_sat(resSat), .busy(busy)
  );

  popcnt_share_sched #(.N_REQ(N_REQ), .ACC_W(ACC_SMALL)) dut5 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_last(reqLast), .req_data(reqData), .req_ready(reqReady5),
    .res_valid(resValid5), .res_ready(resReady), .res_count(resCount5), .res_id(resId5),
    .res_sat(resSat5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popRef(input logic [15:0] d);
    int c = 0;
    for (int i = 0; i < 16; i++) if (d[i]) c++;
    return c;
  endfunction

  task automatic pushExpected(input int id, input int total);
    exp_t e;
    e.id    = id;
    e.count = (total > MAX_MAIN) ? MAX_MAIN : total;
    e.sat   = (total > MAX_MAIN);
    sbMain.push_back(e);
    e.count = (total > MAX_SMALL) ? MAX_SMALL : total;
    e.sat   = (total > MAX_SMALL);
    sbSmall.push_back(e);
  endtask

  // Starts and ends on a falling edge; returns in the cycle right after the last beat transfers.
  task automatic sendPacket(input int id, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input int n,
                            output int firstReady, output int readyCycles, output bit timedOut);
    logic [15:0] beats [3];
    int idx = 0;
    int cyc = 0;
    int total = 0;
    logic x;
    beats[0] = b0; beats[1] = b1; beats[2] = b2;
    for (int i = 0; i < n; i++) total += popRef(beats[i]);
    pushExpected(id, total);
    firstReady  = -1;
    readyCycles = 0;
    timedOut    = 1'b0;
    reqValid[id] = 1'b1;
    while (idx < n) begin
      reqData[id*16 +: 16] = beats[idx];
      reqLast[id] = (idx == n - 1);
      x = reqReady[id];
      if (x === 1'b1) begin
        if (firstReady < 0) firstReady = cyc;
        readyCycles++;
      end
      @(negedge clk);
      cyc++;
      if (x === 1'b1) idx++;
      if (cyc > 50) begin
        timedOut = 1'b1;
        break;
      end
    end
    reqValid[id] = 1'b0;
    reqLast[id]  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %0b expected 0", resValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", reqReady); end
    checks++; if (resCount !== '0 || resId !== '0 || resSat !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_result_regs: got count=%0d id=%0d sat=%0b expected all 0", resCount, resId, resSat);
    end
    checks++; if (resCount5 !== '0 || busy5 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_small_inst: got count=%0d busy=%0b expected 0", resCount5, busy5);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int fr, rc;
    bit to;
    exp_t e, s;
    resReady = 1'b1;
    sendPacket(2, 16'hFFFF, 16'h0001, 16'h8421, 3, fr, rc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout: got %0b expected 0", to); end
    checks++; if (fr != 1) begin errors++; $display("[TB] FAIL single_grant_latency: got %0d expected 1", fr); end
    checks++; if (rc != 3) begin errors++; $display("[TB] FAIL single_ready_cycles: got %0d expected 3", rc); end
    e = sbMain.pop_front();
    s = sbSmall.pop_front();
    checks++; if (resValid !== 1'b1) begin errors++; $display("[TB] FAIL single_res_valid: got %0b expected 1", resValid); end
    checks++; if (resCount !== e.count) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", resCount, e.count); end
    checks++; if (resId !== e.id) begin errors++; $display("[TB] FAIL single_id: got %0d expected %0d", resId, e.id); end
    checks++; if (resSat !== e.sat) begin errors++; $display("[TB] FAIL single_sat: got %0b expected %0b", resSat, e.sat); end
    checks++; if (resCount5 !== s.count || resSat5 !== s.sat) begin
      errors++; $display("[TB] FAIL single_small: got count=%0d sat=%0b expected %0d/%0b", resCount5, resSat5, s.count, s.sat);
    end
    checks++; if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_in_result: got %b expected 0000", reqReady); end
    @(negedge clk);
    checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_falls: got %0b expected 0", resValid); end
  endtask

  task automatic test_round_robin();
    int got = 0;
    int lastCyc = 0;
    exp_t e, s;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resReady = 1'b1;
    foreach (reqData[i]) reqData[i] = 1'b0;
    for (int r = 0; r < N_REQ; r++) reqData[r*16 +: 16] = 16'h00FF;
    pushExpected(0, popRef(16'h00FF));
    pushExpected(1, popRef(16'h00FF));
    pushExpected(2, popRef(16'h00FF));
    pushExpected(3, popRef(16'h00FF));
    pushExpected(0, popRef(16'h00FF));
    reqValid = '1;
    reqLast  = '1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (resValid === 1'b1) begin
        e = sbMain.pop_front();
        s = sbSmall.pop_front();
        checks++; if (resId !== e.id) begin errors++; $display("[TB] FAIL rr_grant_order[%0d]: got %0d expected %0d", got, resId, e.id); end
        checks++; if (resCount !== e.count) begin errors++; $display("[TB] FAIL rr_count[%0d]: got %0d expected %0d", got, resCount, e.count); end
        checks++; if (resCount5 !== s.count) begin errors++; $display("[TB] FAIL rr_small_count[%0d]: got %0d expected %0d", got, resCount5, s.count); end
        if (got > 0) begin
          checks++; if (cyc - lastCyc != 3) begin errors++; $display("[TB] FAIL rr_period[%0d]: got %0d expected 3", got, cyc - lastCyc); end
        end
        lastCyc = cyc;
        got++;
        if (got == 5) begin
          reqValid = '0;
          reqLast  = '0;
        end
      end
      @(negedge clk);
    end
    checks++; if (got != 5) begin errors++; $display("[TB] FAIL rr_result_total: got %0d expected 5", got); end
    reqValid = '0;
    reqLast  = '0;
  endtask

  task automatic test_backpressure();
    int fr, rc;
    bit to;
    exp_t held, e, s;
    resReady = 1'b0;
    sendPacket(1, 16'h0F0F, 16'h0000, 16'h0000, 1, fr, rc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout: got %0b expected 0", to); end
    held = sbMain.pop_front();
    s = sbSmall.pop_front();
    checks++; if (resCount5 !== s.count) begin errors++; $display("[TB] FAIL bp_small_count: got %0d expected %0d", resCount5, s.count); end
    // After owner 1 the pointer sits at 2, so requester 3 is served before requester 0.
    reqData[3*16 +: 16] = 16'h7000; reqLast[3] = 1'b1; reqValid[3] = 1'b1;
    reqData[0*16 +: 16] = 16'h0003; reqLast[0] = 1'b1; reqValid[0] = 1'b1;
    pushExpected(3, popRef(16'h7000));
    pushExpected(0, popRef(16'h0003));
    for (int k = 0; k < 5; k++) begin
      checks++; if (resValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_held[%0d]: got %0b expected 1", k, resValid); end
      checks++; if (resCount !== held.count) begin errors++; $display("[TB] FAIL bp_count_held[%0d]: got %0d expected %0d", k, resCount, held.count); end
      checks++; if (resId !== held.id) begin errors++; $display("[TB] FAIL bp_id_held[%0d]: got %0d expected %0d", k, resId, held.id); end
      checks++; if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready_blocked[%0d]: got %b expected 0000", k, reqReady); end
      @(negedge clk);
    end
    resReady = 1'b1;
    @(negedge clk);
    checks++; if (resValid !== 1'b0 || reqReady !== 4'b0000) begin
      errors++; $display("[TB] FAIL bp_idle_after_handshake: got valid=%0b ready=%b expected 0/0000", resValid, reqReady);
    end
    @(negedge clk);
    checks++; if (reqReady !== 4'b1000) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 1000", reqReady); end
    @(negedge clk);
    reqValid[3] = 1'b0; reqLast[3] = 1'b0;
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (resValid !== 1'b1 || resId !== e.id || resCount !== e.count) begin
      errors++; $display("[TB] FAIL bp_req3_result: got v=%0b id=%0d count=%0d expected 1/%0d/%0d", resValid, resId, resCount, e.id, e.count);
    end
    repeat (2) @(negedge clk);
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL bp_grant_req0: got %b expected 0001", reqReady); end
    @(negedge clk);
    reqValid[0] = 1'b0; reqLast[0] = 1'b0;
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (resValid !== 1'b1 || resId !== e.id || resCount !== e.count) begin
      errors++; $display("[TB] FAIL bp_req0_result: got v=%0b id=%0d count=%0d expected 1/%0d/%0d", resValid, resId, resCount, e.id, e.count);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int fr, rc;
    bit to;
    exp_t e, s;
    resReady = 1'b1;
    sendPacket(1, 16'hFFFF, 16'hFFFF, 16'h0003, 3, fr, rc, to);
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (to !== 1'b0 || resValid5 !== 1'b1) begin errors++; $display("[TB] FAIL sat_result_present: got to=%0b valid=%0b expected 0/1", to, resValid5); end
    checks++; if (resCount5 !== s.count) begin errors++; $display("[TB] FAIL sat_count: got %0d expected %0d", resCount5, s.count); end
    checks++; if (resSat5 !== s.sat) begin errors++; $display("[TB] FAIL sat_flag: got %0b expected %0b", resSat5, s.sat); end
    checks++; if (resId5 !== s.id) begin errors++; $display("[TB] FAIL sat_id: got %0d expected %0d", resId5, s.id); end
    checks++; if (resCount !== e.count || resSat !== e.sat) begin
      errors++; $display("[TB] FAIL sat_wide_count: got %0d/%0b expected %0d/%0b", resCount, resSat, e.count, e.sat);
    end
    @(negedge clk);
    sendPacket(1, 16'h0001, 16'h0000, 16'h0000, 1, fr, rc, to);
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (resCount5 !== s.count) begin errors++; $display("[TB] FAIL sat_next_count: got %0d expected %0d", resCount5, s.count); end
    checks++; if (resSat5 !== s.sat) begin errors++; $display("[TB] FAIL sat_cleared: got %0b expected %0b", resSat5, s.sat); end
    @(negedge clk);
  endtask

  task automatic test_stall_reset();
    exp_t e, s;
    resReady = 1'b1;
    pushExpected(2, popRef(16'h00FF) + popRef(16'h0F0F));
    reqData[2*16 +: 16] = 16'h00FF; reqLast[2] = 1'b0; reqValid[2] = 1'b1;
    @(negedge clk);
    checks++; if (reqReady !== 4'b0100) begin errors++; $display("[TB] FAIL stall_grant: got %b expected 0100", reqReady); end
    @(negedge clk);
    reqValid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (reqReady !== 4'b0100 || busy !== 1'b1 || resValid !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold[%0d]: got ready=%b busy=%0b valid=%0b expected 0100/1/0", k, reqReady, busy, resValid);
      end
      @(negedge clk);
    end
    reqData[2*16 +: 16] = 16'h0F0F; reqLast[2] = 1'b1; reqValid[2] = 1'b1;
    @(negedge clk);
    reqValid[2] = 1'b0; reqLast[2] = 1'b0;
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (resValid !== 1'b1 || resCount !== e.count || resId !== e.id) begin
      errors++; $display("[TB] FAIL stall_result: got v=%0b count=%0d id=%0d expected 1/%0d/%0d", resValid, resCount, resId, e.count, e.id);
    end
    @(negedge clk);
    reqData[2*16 +: 16] = 16'hFFFF; reqLast[2] = 1'b0; reqValid[2] = 1'b1;
    @(negedge clk);
    reqData[1*16 +: 16] = 16'h0001; reqLast[1] = 1'b1; reqValid[1] = 1'b1;
    reqData[3*16 +: 16] = 16'h0300; reqLast[3] = 1'b1; reqValid[3] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reqValid[2] = 1'b0;
    pushExpected(1, popRef(16'h0001));
    checks++; if (busy !== 1'b0 || resValid !== 1'b0 || reqReady !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_discard: got busy=%0b valid=%0b ready=%b expected 0/0/0000", busy, resValid, reqReady);
    end
    @(negedge clk);
    checks++; if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL reset_ptr_grant: got %b expected 0010", reqReady); end
    checks++; if (resValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_result: got %0b expected 0", resValid); end
    @(negedge clk);
    reqValid = '0; reqLast = '0;
    e = sbMain.pop_front(); s = sbSmall.pop_front();
    checks++; if (resValid !== 1'b1 || resId !== e.id || resCount !== e.count) begin
      errors++; $display("[TB] FAIL reset_next_result: got v=%0b id=%0d count=%0d expected 1/%0d/%0d", resValid, resId, resCount, e.id, e.count);
    end
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqLast  = '0;
    reqData  = '0;
    resReady = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_stall_reset();
    checks++; if (sbMain.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drained: got %0d expected 0", sbMain.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
